// File: rtl/fifo_pkg.sv
// fifo_pkg: types and defaults shared by the synchronous FIFO and its
// read-side streamer.
package fifo_pkg;

  // Default word width and depth of the FIFO this stage sits behind.
  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 16;

  // Default width of the delivered-word counter in the streamer.
  localparam int CNT_WIDTH = 16;

  // Number of words the skid buffer can hold.
  localparam logic [1:0] SKID_DEPTH = 2'd2;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
  typedef logic [1:0]            skid_occ_t;

  // True when the words already committed to the skid buffer (held plus
  // in flight), minus a word leaving this cycle, still leave room for one
  // more read. A transfer only happens when occ is non-zero, so the
  // subtraction never goes below zero.
  function automatic logic slot_free(input skid_occ_t occ,
                                     input logic      inflight,
                                     input logic      xfer);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
    return committed < {1'b0, SKID_DEPTH};
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry register pair used as a tiny FIFO. The head entry
// is always presented on dout; count reports how many entries are valid.
module fifo_skid_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);
  import fifo_pkg::*;

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             head;
  logic             tail;
  skid_occ_t        occ;
  logic             do_push;
  logic             do_pop;

  // A pop of an empty buffer is ignored; a push into a full buffer is only
  // honoured when the head leaves in the same cycle.
  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push && ((occ != SKID_DEPTH) || do_pop);

  // Write the incoming word into the slot the tail points at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
    end else if (do_push) begin
      if (tail) begin
        slot1 <= din;
      end else begin
        slot0 <= din;
      end
    end
  end

  // Advance head/tail pointers and keep the occupancy in step with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (do_push) begin
        tail <= ~tail;
      end
      if (do_pop) begin
        head <= ~head;
      end
      occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dout  = head ? slot1 : slot0;
  assign count = occ;

endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: drains a synchronous FIFO with a registered read port
// and re-presents its words on a valid/ready stream with no bubbles.
module fifo_rd_streamer #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic                  busy
);
  import fifo_pkg::*;

  skid_occ_t occ;
  logic      inflight;
  logic      xfer;

  assign m_valid = (occ != 2'd0);
  assign xfer    = m_valid && m_ready;

  // A read is issued only when the word it returns is guaranteed a slot.
  // Counting the same-cycle transfer lets the stream run at full rate, and
  // is the intended combinational path from m_ready to fifo_rd_en.
  assign fifo_rd_en = rst_n && !fifo_empty && slot_free(occ, inflight, xfer);

  // Remember that the FIFO will present a word on its output next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // Count stream handshakes; the counter wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_count <= '0;
    end else if (xfer) begin
      pop_count <= pop_count + CNT_WIDTH'(1);
    end
  end

  assign busy = m_valid || inflight;

  // The FIFO output is registered into the skid buffer, so m_data never
  // depends combinationally on fifo_data_out.
  fifo_skid_buf #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (fifo_data_out),
    .pop   (xfer),
    .dout  (m_data),
    .count (occ)
  );

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: drives the streamer from a behavioural FIFO and
// scores the stream against the words written into that FIFO.
module tb_fifo_rd_streamer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_data_out;
  logic         fifo_rd_en;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic [15:0]  pop_count;
  logic         busy;

  logic         fifo_rd_en_w;
  logic         m_valid_w;
  logic [W-1:0] m_data_w;
  logic [3:0]   pop_count_w;
  logic         busy_w;

  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;

  logic [W-1:0] fmem [0:31];
  logic [4:0]   wptr;
  logic [4:0]   rptr;
  logic [5:0]   fcnt;

  logic [W-1:0] exp_q [$];
  int           n_compared = 0;
  int           n_mismatched = 0;
  int           rd_total = 0;
  int           xfer_total = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         rnd_run = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_streamer #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .pop_count     (pop_count),
    .busy          (busy)
  );

  // Narrow-counter twin: same inputs, so it tracks the main instance and
  // exposes the counter wrap.
  fifo_rd_streamer #(.FIFO_WIDTH(W), .CNT_WIDTH(4)) dut_w (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en_w),
    .m_valid       (m_valid_w),
    .m_ready       (m_ready),
    .m_data        (m_data_w),
    .pop_count     (pop_count_w),
    .busy          (busy_w)
  );

  // Behavioural synchronous FIFO with a one-cycle registered read.
  assign fifo_empty = (fcnt == 6'd0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
      fifo_data_out <= '0;
    end else begin
      if (wr_en) begin
        fmem[wptr] <= wr_data;
        wptr <= wptr + 5'd1;
      end
      if (fifo_rd_en && !fifo_empty) begin
        fifo_data_out <= fmem[rptr];
        rptr <= rptr + 5'd1;
      end
      fcnt <= fcnt + {5'd0, wr_en} - {5'd0, (fifo_rd_en && !fifo_empty)};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one word into the FIFO and record it as the next expected word.
  task automatic applyStimulus(input logic [W-1:0] data);
    wr_en = 1'b1;
    wr_data = data;
    exp_q.push_back(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic doReset();
    wr_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("rst_pop_count", 32'(pop_count), 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  // Wait (bounded) until every written word has been delivered.
  task automatic waitDrain(input string name, input int budget);
    int c;
    for (c = 0; c < budget; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    checkOutput(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: scoreboard compare on each handshake plus stream invariants.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      rd_total = 0;
      xfer_total = 0;
      prev_stall = 1'b0;
    end else begin
      if (fifo_rd_en && fifo_empty)
        checkOutput("rd_en_while_empty", 32'd1, 32'd0);
      if (rd_total - xfer_total > 2)
        checkOutput("skid_overflow", 32'(rd_total - xfer_total), 32'd2);
      if (prev_stall) begin
        checkOutput("stall_valid_hold", 32'(m_valid), 32'd1);
        checkOutput("stall_data_hold", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, scoreboard empty", m_data);
        end else begin
          checkOutput("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        xfer_total++;
      end
      if (fifo_rd_en) rd_total++;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int run;
    logic started;
    logic saw15;
    logic saw_wrap;
    int written;
    int rd_seen;

    // Single word: latency, data and counter.
    m_ready = 1'b1;
    doReset();
    applyStimulus(16'hA5A5);
    @(negedge clk);
    checkOutput("sw_empty_fell", 32'(fifo_empty), 32'd0);
    checkOutput("sw_rd_en", 32'(fifo_rd_en), 32'd1);
    checkOutput("sw_valid_c0", 32'(m_valid), 32'd0);
    @(negedge clk);
    checkOutput("sw_valid_c1", 32'(m_valid), 32'd0);
    @(negedge clk);
    checkOutput("sw_valid_c2", 32'(m_valid), 32'd1);
    checkOutput("sw_data", 32'(m_data), 32'h0000A5A5);
    repeat (3) @(negedge clk);
    checkOutput("sw_pop_count", 32'(pop_count), 32'd1);
    checkOutput("sw_rd_pulses", 32'(rd_total), 32'd1);
    checkOutput("sw_busy_idle", 32'(busy), 32'd0);

    // Full drain: eight words back to back, no gap after the first.
    doReset();
    run = 0;
    started = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(16'(i));
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (m_valid && m_ready) begin
            run++;
            started = 1'b1;
          end else if (started) begin
            break;
          end
        end
      end
    join
    checkOutput("drain_run_len", 32'(run), 32'd8);
    checkOutput("drain_pop_count", 32'(pop_count), 32'd8);
    checkOutput("drain_left", 32'(exp_q.size()), 32'd0);

    // Backpressure: only two reads while stalled, then a clean release.
    m_ready = 1'b0;
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(16'(i));
    repeat (4) @(negedge clk);
    checkOutput("bp_rd_pulses", 32'(rd_total), 32'd2);
    checkOutput("bp_busy", 32'(busy), 32'd1);
    checkOutput("bp_valid", 32'(m_valid), 32'd1);
    checkOutput("bp_data", 32'(m_data), 32'h0);
    checkOutput("bp_rd_low", 32'(fifo_rd_en), 32'd0);
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_rd_on_release", 32'(fifo_rd_en), 32'd1);
    waitDrain("bp_drain", 100);
    checkOutput("bp_pop_count", 32'(pop_count), 32'd8);

    // Random ready and random writes, 1000 words.
    doReset();
    rnd_run = 1'b1;
    fork
      begin
        while (rnd_run) begin
          m_ready = 1'($urandom_range(1, 0));
          tick();
        end
      end
    join_none
    written = 0;
    while (written < 1000) begin
      if ($urandom_range(1, 0) == 1 && fcnt < 6'd20) begin
        wr_en = 1'b1;
        wr_data = 16'($urandom_range(65535, 0));
        exp_q.push_back(wr_data);
        written++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    waitDrain("rnd_drain", 5000);
    rnd_run = 1'b0;
    tick();
    tick();
    m_ready = 1'b1;
    checkOutput("rnd_xfers", 32'(xfer_total), 32'd1000);
    checkOutput("rnd_pop_count", 32'(pop_count), 32'd1000);

    // Reset mid-stream with one word held and one in flight.
    m_ready = 1'b0;
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(16'h0C00 + 16'(i));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    checkOutput("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_rst_data", 32'(m_data), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_seen++;
    end
    checkOutput("mid_no_rd_idle", 32'(rd_seen), 32'd0);
    tick();
    m_ready = 1'b1;
    applyStimulus(16'h5A5A);
    waitDrain("mid_new_word", 50);
    checkOutput("mid_pop_count", 32'(pop_count), 32'd1);

    // Counter wrap on the 4-bit twin: 17 words end at 1.
    doReset();
    saw15 = 1'b0;
    saw_wrap = 1'b0;
    fork
      begin
        for (int i = 0; i < 17; i++) applyStimulus(16'h0100 + 16'(i));
      end
      begin
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (pop_count_w == 4'd15) saw15 = 1'b1;
          if (saw15 && pop_count_w == 4'd0) saw_wrap = 1'b1;
          if (c > 2 && exp_q.size() == 0 && !busy) break;
        end
      end
    join
    checkOutput("wrap_passed_15_0", 32'(saw_wrap), 32'd1);
    checkOutput("wrap_pop_count_w", 32'(pop_count_w), 32'd1);
    checkOutput("wrap_pop_count", 32'(pop_count), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
